lcd_spi_rx: RTL and testbench
=============================

LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 32'd320, panel columns.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 32'd240, panel rows.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports lcd_spi_sclk, lcd_spi_mosi, lcd_spi_cs, lcd_dc and lcd_reset, each input, 1, asynchronous to sys_clk:
- lcd_spi_sclk: SPI clock.
- lcd_spi_mosi: SPI data.
- lcd_spi_cs: SPI chip select, active-low.
- lcd_dc: 0 = command, 1 = data.
- lcd_reset: panel reset, active-low.
REQ-006 SHALL have port byte_valid, output, 1, one-cycle pulse per received byte.
REQ-007 SHALL have port byte_data, output, 8, last received byte.
REQ-008 SHALL have port byte_is_data, output, 1, lcd_dc captured with that byte.
REQ-009 SHALL have port pix_valid, output, 1, one-cycle pulse per decoded pixel.
REQ-010 SHALL have ports pix_data, pix_x and pix_y, each output, 16:
- pix_data: RGB565 pixel.
- pix_x: column of the pixel.
- pix_y: row of the pixel.
REQ-011 SHALL have port frame_done, output, 1, pulse on the last pixel of the window.
REQ-012 SHALL have port win_err, output, 1, pulse when a CASET or RASET is rejected.

Function
REQ-013 SHALL synchronise sclk, mosi, cs, dc and lcd_reset through 2-flop synchronisers; sys_clk >= 4x sclk is required.
REQ-014 SHALL sample mosi on each synchronised sclk rising edge while cs is low (SPI mode 0), MSB first.
REQ-015 SHALL capture dc on the 8th bit's sclk rising edge.
REQ-016 SHALL pulse byte_valid exactly one sys_clk after the 8th synchronised rising edge is detected, with byte_data and byte_is_data held until the next byte.
REQ-017 SHALL discard a partial byte and clear the bit count when cs goes high; the decoder state SHALL be unaffected by cs.
REQ-018 SHALL implement decoder FSM states IDLE, CASET, RASET and RAMWR.
REQ-019 SHALL, on any command byte (dc=0), enter a state regardless of the current state:
- 0x2A -> CASET.
- 0x2B -> RASET.
- 0x2C -> RAMWR.
- any other opcode -> IDLE.
REQ-020 SHALL, in CASET/RASET, collect 4 data bytes in the order start-hi, start-lo, end-hi, end-lo.
REQ-021 SHALL ignore further data bytes after the 4th; the FSM stays in its state until the next command.
REQ-022 SHALL, on the 4th CASET byte, commit xs/xe only if xs <= xe < SCREEN_WIDTH; otherwise keep the old window and pulse win_err.
REQ-023 SHALL apply the same rule to RASET with ys/ye and SCREEN_HEIGHT.
REQ-024 SHALL, on entry to RAMWR, load cur_x = xs, cur_y = ys and clear the byte-pair flag.
REQ-025 SHALL, in RAMWR, take the first data byte as pix_data[15:8] and the second as [7:0].
REQ-026 SHALL pulse pix_valid one cycle after the second byte's byte_valid, with pix_x = cur_x and pix_y = cur_y.
REQ-027 SHALL advance the address after each pixel as follows:
- cur_x == xe: cur_x = xs and cur_y increments.
- cur_x == xe and cur_y == ye: cur_y = ys and frame_done pulses in the same cycle as that pix_valid.
REQ-028 SHALL discard a dangling high byte when a command arrives; a dangling high byte SHALL survive a cs high.
REQ-029 SHALL store data bytes received in IDLE in no state; only byte_valid reports them.
REQ-030 SHALL assert outputs only for one cycle per event; no two byte_valid pulses are closer than 8 sclk periods.

Reset
REQ-031 SHALL, on sys_rst_n low, asynchronously clear the following:
- Every output is 0.
- The FSM is in IDLE.
- The bit count is 0.
- The window is xs=0, xe=SCREEN_WIDTH-1, ys=0, ye=SCREEN_HEIGHT-1.
REQ-032 SHALL, while synchronised lcd_reset is low, hold the decoder and shifter in the REQ-031 state synchronously; outputs are 0.
REQ-033 SHALL, on reset mid-byte or mid-pixel, lose the partial data with no pulses emitted.

Structure
REQ-034 SHALL place opcodes CMD_CASET=8'h2A, CMD_RASET=8'h2B and CMD_RAMWR=8'h2C, plus the FSM state encoding, in shared package lcd_pkg.
REQ-035 SHALL put the synchronisers, edge detect and shift register in sub-module spi_byte_rx (outputs byte_valid, byte_data, byte_is_data); lcd_spi_rx holds the decoder.

Verification
REQ-036 SHALL cover a byte with dc=0 at sys_clk = 8x sclk: byte 0xA5 -> exactly one byte_valid, byte_data=0xA5, byte_is_data=0.
REQ-037 SHALL cover a window write:
- Send CASET 0,10,0,11, then RASET 0,20,0,21, then RAMWR followed by 4 pixels 0xF800,0x07E0,0x001F,0xFFFF.
- Required: pixels at (10,20),(11,20),(10,21),(11,21), with frame_done on the 4th only.
REQ-038 SHALL cover a rejected window: CASET 0,50,0,40 -> win_err pulse; the next RAMWR pixel lands at the prior xs/ys.
REQ-039 SHALL cover partial-byte abort: cs high after 5 bits, then full byte 0x3C -> a single byte_valid with 0x3C.
REQ-040 SHALL cover RAMWR byte-pair handling:
- RAMWR data 0x12, then cs high, then 0x34 -> pix_data=0x1234.
- RAMWR data 0x12, then command 0x2C, then 0xAB,0xCD -> pix_data=0xABCD at (xs,ys).
REQ-041 SHALL cover reset mid-RAMWR: lcd_reset pulsed low -> FSM in IDLE, window at defaults, no pix_valid until a new RAMWR.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared opcodes, decoder state encoding and window check for the LCD SPI receiver.
package lcd_pkg;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  typedef enum logic [1:0] {ST_IDLE, ST_CASET, ST_RASET, ST_RAMWR} state_t;
  // A window is legal when start <= end and end does not exceed the last column/row.
  function automatic logic win_ok(input logic [15:0] s, input logic [15:0] e, input logic [15:0] lim);
    return s <= e && e <= lim;
  endfunction
endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: synchronises the SPI/LCD pins into sys_clk and assembles mode-0, MSB-first bytes.
//   sys_clk, sys_rst_n          : clock and asynchronous active-low reset
//   sclk, mosi, cs, dc, lcd_reset: raw asynchronous panel-side pins
//   lcd_rst_s                   : synchronised lcd_reset (active-low)
//   byte_valid                  : one-cycle pulse per completed byte
//   byte_data, byte_is_data     : byte and its captured dc, held until the next byte
module spi_byte_rx (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  input  logic       dc,
  input  logic       lcd_reset,
  output logic       lcd_rst_s,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data
);
  logic [1:0] sclk_q, mosi_q, cs_q, dc_q, rst_q;
  logic       sclk_d;
  logic [2:0] cnt;
  logic [6:0] sh;
  logic       rise;

  assign lcd_rst_s = rst_q[1];
  // mosi travels through the same two stages as sclk, so it stays aligned with the detected edge.
  assign rise = sclk_q[1] & ~sclk_d & ~cs_q[1];

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      sclk_q <= '0;
      mosi_q <= '0;
      cs_q   <= 2'b11;
      dc_q   <= '0;
      rst_q  <= '0;
      sclk_d <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[0], sclk};
      mosi_q <= {mosi_q[0], mosi};
      cs_q   <= {cs_q[0], cs};
      dc_q   <= {dc_q[0], dc};
      rst_q  <= {rst_q[0], lcd_reset};
      sclk_d <= sclk_q[1];
    end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      cnt          <= '0;
      sh           <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_data <= 1'b0;
    end else if (!rst_q[1]) begin
      cnt          <= '0;
      sh           <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_data <= 1'b0;
    end else begin
      byte_valid <= rise && cnt == 3'd7;
      if (cs_q[1])
        cnt <= '0;
      else if (rise) begin
        sh  <= {sh[5:0], mosi_q[1]};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          byte_data    <= {sh, mosi_q[1]};
          byte_is_data <= dc_q[1];
        end
      end
    end
endmodule

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: LCD SPI sniffer decoding CASET/RASET/RAMWR into addressed RGB565 pixels.
//   sys_clk, sys_rst_n                          : clock and asynchronous active-low reset
//   lcd_spi_sclk/mosi/cs, lcd_dc, lcd_reset     : raw panel pins (asynchronous)
//   byte_valid, byte_data, byte_is_data         : every received byte
//   pix_valid, pix_data, pix_x, pix_y           : one decoded pixel and its address
//   frame_done                                  : with the last pixel of the window
//   win_err                                     : CASET/RASET window rejected
module lcd_spi_rx import lcd_pkg::*; #(
  parameter logic [31:0] SCREEN_WIDTH  = 32'd320,
  parameter logic [31:0] SCREEN_HEIGHT = 32'd240
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        lcd_spi_sclk,
  input  logic        lcd_spi_mosi,
  input  logic        lcd_spi_cs,
  input  logic        lcd_dc,
  input  logic        lcd_reset,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_data,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        frame_done,
  output logic        win_err
);
  localparam logic [15:0] W_MAX = 16'(SCREEN_WIDTH - 32'd1);
  localparam logic [15:0] H_MAX = 16'(SCREEN_HEIGHT - 32'd1);

  state_t      state, state_nx;
  logic        lcd_rst_s;
  logic        is_cmd, is_dat, in_win, last, ok, pix_go;
  logic [2:0]  idx;
  logic [23:0] prm;
  logic [15:0] xs, xe, ys, ye, cur_x, cur_y;
  logic [7:0]  hi;
  logic        have_hi;

  spi_byte_rx u_rx (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sclk         (lcd_spi_sclk),
    .mosi         (lcd_spi_mosi),
    .cs           (lcd_spi_cs),
    .dc           (lcd_dc),
    .lcd_reset    (lcd_reset),
    .lcd_rst_s    (lcd_rst_s),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n)
      state <= ST_IDLE;
    else
      state <= lcd_rst_s ? state_nx : ST_IDLE;

  always_comb begin
    state_nx = state;
    is_cmd   = byte_valid & ~byte_is_data;
    is_dat   = byte_valid & byte_is_data;
    in_win   = state == ST_CASET || state == ST_RASET;
    last     = is_dat && in_win && idx == 3'd3;
    // prm holds start-hi, start-lo, end-hi; the current byte is end-lo.
    ok       = win_ok(prm[23:8], {prm[7:0], byte_data}, state == ST_CASET ? W_MAX : H_MAX);
    pix_go   = is_dat && state == ST_RAMWR && have_hi;
    if (is_cmd)
      state_nx = byte_data == CMD_CASET ? ST_CASET :
                 byte_data == CMD_RASET ? ST_RASET :
                 byte_data == CMD_RAMWR ? ST_RAMWR : ST_IDLE;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      idx        <= '0;
      prm        <= '0;
      xs         <= '0;
      xe         <= W_MAX;
      ys         <= '0;
      ye         <= H_MAX;
      cur_x      <= '0;
      cur_y      <= '0;
      hi         <= '0;
      have_hi    <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
      win_err    <= 1'b0;
    end else if (!lcd_rst_s) begin
      idx        <= '0;
      prm        <= '0;
      xs         <= '0;
      xe         <= W_MAX;
      ys         <= '0;
      ye         <= H_MAX;
      cur_x      <= '0;
      cur_y      <= '0;
      hi         <= '0;
      have_hi    <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
      win_err    <= 1'b0;
    end else begin
      pix_valid  <= pix_go;
      frame_done <= pix_go && cur_x == xe && cur_y == ye;
      win_err    <= last && !ok;
      if (is_cmd) begin
        idx     <= '0;
        have_hi <= 1'b0;
        if (byte_data == CMD_RAMWR) begin
          cur_x <= xs;
          cur_y <= ys;
        end
      end else if (is_dat) begin
        // idx saturates at 4 so bytes beyond the fourth are ignored.
        if (in_win && idx != 3'd4) begin
          prm <= {prm[15:0], byte_data};
          idx <= idx + 3'd1;
          if (last && ok && state == ST_CASET) begin
            xs <= prm[23:8];
            xe <= {prm[7:0], byte_data};
          end
          if (last && ok && state == ST_RASET) begin
            ys <= prm[23:8];
            ye <= {prm[7:0], byte_data};
          end
        end
        if (state == ST_RAMWR) begin
          if (!have_hi) begin
            hi      <= byte_data;
            have_hi <= 1'b1;
          end else begin
            have_hi  <= 1'b0;
            pix_data <= {hi, byte_data};
            pix_x    <= cur_x;
            pix_y    <= cur_y;
            if (cur_x == xe) begin
              cur_x <= xs;
              cur_y <= cur_y == ye ? ys : cur_y + 16'd1;
            end else
              cur_x <= cur_x + 16'd1;
          end
        end
      end
    end
endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb_lcd_spi_rx: directed byte-table plus hand sequences for lcd_spi_rx at sys_clk = 8x sclk.
module tb_lcd_spi_rx;
  logic        sys_clk = 0, sys_rst_n = 0;
  logic        lcd_spi_sclk = 0, lcd_spi_mosi = 0, lcd_spi_cs = 1, lcd_dc = 0, lcd_reset = 1;
  logic        byte_valid, byte_is_data, pix_valid, frame_done, win_err;
  logic [7:0]  byte_data;
  logic [15:0] pix_data, pix_x, pix_y;

  lcd_spi_rx dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .lcd_spi_sclk (lcd_spi_sclk),
    .lcd_spi_mosi (lcd_spi_mosi),
    .lcd_spi_cs   (lcd_spi_cs),
    .lcd_dc       (lcd_dc),
    .lcd_reset    (lcd_reset),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .frame_done   (frame_done),
    .win_err      (win_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        dc;
    logic [7:0]  b;
    logic        pix;
    logic [15:0] pd, px, py;
    logic        fd, err;
  } vec_t;

  vec_t v[$];
  int   tests = 0, failed = 0;
  int   nb = 0, np = 0, nf = 0, ne = 0, wide = 0, orphan = 0;
  logic [7:0]  lb;
  logic        ld;
  logic [15:0] lp, lx, ly;
  logic        prev_bv = 0, prev_pv = 0;

  always @(negedge sys_clk) begin
    if (byte_valid) begin nb++; lb = byte_data; ld = byte_is_data; end
    if (pix_valid) begin np++; lp = pix_data; lx = pix_x; ly = pix_y; end
    if (frame_done) nf++;
    if (win_err) ne++;
    if ((byte_valid && prev_bv) || (pix_valid && prev_pv)) wide++;
    if (frame_done && !pix_valid) orphan++;
    prev_bv = byte_valid;
    prev_pv = pix_valid;
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic send(input logic d, input logic [7:0] b, input int n = 8);
    lcd_dc = d;
    lcd_spi_cs = 0;
    for (int i = 7; i > 7 - n; i--) begin
      lcd_spi_mosi = b[i];
      #40 lcd_spi_sclk = 1;
      #40 lcd_spi_sclk = 0;
    end
    #200;
  endtask

  task automatic add(input logic dc, input logic [7:0] b, input logic pix, input logic [15:0] pd,
                     input logic [15:0] px, input logic [15:0] py, input logic fd, input logic err);
    vec_t t;
    t.dc = dc; t.b = b; t.pix = pix; t.pd = pd; t.px = px; t.py = py; t.fd = fd; t.err = err;
    v.push_back(t);
  endtask
  task automatic c(input logic [7:0] b); add(1'b0, b, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0); endtask
  task automatic d(input logic [7:0] b); add(1'b1, b, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0); endtask
  task automatic e(input logic [7:0] b); add(1'b1, b, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1); endtask
  task automatic p(input logic [7:0] b, input logic [15:0] pd, input logic [15:0] px,
                   input logic [15:0] py, input logic fd);
    add(1'b1, b, 1'b1, pd, px, py, fd, 1'b0);
  endtask

  initial begin
    int b0, p0, f0, e0;
    c(8'hA5);
    c(8'h2A); d(8'h00); d(8'h0A); d(8'h00); d(8'h0B);
    c(8'h2B); d(8'h00); d(8'h14); d(8'h00); d(8'h15);
    c(8'h2C);
    d(8'hF8); p(8'h00, 16'hF800, 16'd10, 16'd20, 1'b0);
    d(8'h07); p(8'hE0, 16'h07E0, 16'd11, 16'd20, 1'b0);
    d(8'h00); p(8'h1F, 16'h001F, 16'd10, 16'd21, 1'b0);
    d(8'hFF); p(8'hFF, 16'hFFFF, 16'd11, 16'd21, 1'b1);
    c(8'h2A); d(8'h00); d(8'h32); d(8'h00); e(8'h28);
    c(8'h2C); d(8'h11); p(8'h22, 16'h1122, 16'd10, 16'd20, 1'b0);
    c(8'h00); d(8'h55);
    c(8'h2A); d(8'h00); d(8'h0A); d(8'h00); d(8'h0B); d(8'h77);
    c(8'h2A); d(8'h00); d(8'h00); d(8'h01); e(8'h40);
    c(8'h2B); d(8'h00); d(8'hEF); d(8'h00); d(8'hEF);
    c(8'h2C);
    d(8'hAB); p(8'hCD, 16'hABCD, 16'd10, 16'd239, 1'b0);
    d(8'h01); p(8'h02, 16'h0102, 16'd11, 16'd239, 1'b1);

    #25;
    chk("rst byte_valid", 32'(byte_valid), 32'd0);
    chk("rst byte_data", 32'(byte_data), 32'd0);
    chk("rst pix_valid", 32'(pix_valid), 32'd0);
    chk("rst pix_xy", {pix_x, pix_y}, 32'd0);
    chk("rst pix_data", 32'(pix_data), 32'd0);
    chk("rst flags", {29'd0, byte_is_data, frame_done, win_err}, 32'd0);
    #8 sys_rst_n = 1;
    #200;

    foreach (v[i]) begin
      b0 = nb; p0 = np; f0 = nf; e0 = ne;
      send(v[i].dc, v[i].b);
      chk($sformatf("v%0d byte_cnt", i), nb - b0, 32'd1);
      chk($sformatf("v%0d byte_data", i), 32'(lb), 32'(v[i].b));
      chk($sformatf("v%0d byte_is_data", i), 32'(ld), 32'(v[i].dc));
      chk($sformatf("v%0d pix_cnt", i), np - p0, 32'(v[i].pix));
      if (v[i].pix) begin
        chk($sformatf("v%0d pix_data", i), 32'(lp), 32'(v[i].pd));
        chk($sformatf("v%0d pix_xy", i), {lx, ly}, {v[i].px, v[i].py});
      end
      chk($sformatf("v%0d frame_done", i), nf - f0, 32'(v[i].fd));
      chk($sformatf("v%0d win_err", i), ne - e0, 32'(v[i].err));
    end

    b0 = nb;
    send(1'b0, 8'hFF, 5);
    lcd_spi_cs = 1; #200;
    send(1'b0, 8'h3C);
    chk("abort byte_cnt", nb - b0, 32'd1);
    chk("abort byte_data", 32'(lb), 32'h3C);

    send(1'b0, 8'h2C);
    p0 = np;
    send(1'b1, 8'h12);
    lcd_spi_cs = 1; #200;
    send(1'b1, 8'h34);
    chk("cs_pair pix_cnt", np - p0, 32'd1);
    chk("cs_pair pix_data", 32'(lp), 32'h1234);
    chk("cs_pair pix_xy", {lx, ly}, {16'd10, 16'd239});

    p0 = np;
    send(1'b1, 8'h12);
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAB);
    send(1'b1, 8'hCD);
    chk("cmd_drop pix_cnt", np - p0, 32'd1);
    chk("cmd_drop pix_data", 32'(lp), 32'hABCD);
    chk("cmd_drop pix_xy", {lx, ly}, {16'd10, 16'd239});

    p0 = np; b0 = nb;
    send(1'b1, 8'h56);
    lcd_reset = 0; #200;
    chk("lcd_rst outs", {byte_valid, pix_valid, frame_done, win_err, byte_data, pix_data}, 32'd0);
    lcd_reset = 1; #200;
    send(1'b1, 8'h78);
    send(1'b1, 8'h9A);
    chk("lcd_rst idle pix_cnt", np - p0, 32'd0);
    chk("lcd_rst idle byte_cnt", nb - b0, 32'd3);
    send(1'b0, 8'h2C);
    send(1'b1, 8'h01);
    send(1'b1, 8'h02);
    chk("lcd_rst pix_data", 32'(lp), 32'h0102);
    chk("lcd_rst pix_xy", {lx, ly}, {16'd0, 16'd0});
    send(1'b1, 8'h03);
    send(1'b1, 8'h04);
    chk("lcd_rst pix2_xy", {lx, ly}, {16'd1, 16'd0});
    chk("lcd_rst pix_cnt", np - p0, 32'd2);

    chk("pulse_width", wide, 32'd0);
    chk("frame_done_alone", orphan, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
